// File: rtl/axi4l_if.sv
// AXI4-Lite bundle (32-bit address and data) with master/slave views.
interface axi4l_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi4l_arbiter2.sv
// 2:1 AXI4-Lite arbiter: independent read and write paths, one outstanding
// transaction each, registered round-robin (or fixed-priority) grant.
module axi4l_arbiter2 #(
   parameter bit fixed_priority = 1'b0
) (
   input logic    aclk,
   input logic    aresetn,
   axi4l_if.slave  m0,
   axi4l_if.slave  m1,
   axi4l_if.master s
);

   typedef enum logic [1:0] {WIdle, WFwd, WResp} wstate_e;
   typedef enum logic [1:0] {RIdle, RFwd, RResp} rstate_e;

   wstate_e wstate_q;
   logic    wgnt_q;
   logic    last_wgnt_q;
   logic    aw_done_q;
   logic    w_done_q;

   rstate_e rstate_q;
   logic    rgnt_q;
   logic    last_rgnt_q;

   logic w_fwd, w_resp, r_fwd, r_resp;
   logic w_win, r_win;
   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_all, w_all;

   // Winner is taken only from asserted valids; ties go by policy.
   always_comb begin
      w_win = m1.awvalid;
      if (m0.awvalid && m1.awvalid) begin
         w_win = fixed_priority ? 1'b0 : ~last_wgnt_q;
      end
      r_win = m1.arvalid;
      if (m0.arvalid && m1.arvalid) begin
         r_win = fixed_priority ? 1'b0 : ~last_rgnt_q;
      end
   end

   // Write path routing; everything qualified by state so idle drives zero.
   always_comb begin
      w_fwd      = (wstate_q == WFwd);
      w_resp     = (wstate_q == WResp);
      s.awaddr   = wgnt_q ? m1.awaddr : m0.awaddr;
      s.awprot   = wgnt_q ? m1.awprot : m0.awprot;
      s.wdata    = wgnt_q ? m1.wdata  : m0.wdata;
      s.wstrb    = wgnt_q ? m1.wstrb  : m0.wstrb;
      s.awvalid  = w_fwd & ~aw_done_q & (wgnt_q ? m1.awvalid : m0.awvalid);
      s.wvalid   = w_fwd & ~w_done_q  & (wgnt_q ? m1.wvalid  : m0.wvalid);
      s.bready   = w_resp & (wgnt_q ? m1.bready : m0.bready);
      m0.awready = w_fwd & ~wgnt_q & ~aw_done_q & s.awready;
      m1.awready = w_fwd &  wgnt_q & ~aw_done_q & s.awready;
      m0.wready  = w_fwd & ~wgnt_q & ~w_done_q & s.wready;
      m1.wready  = w_fwd &  wgnt_q & ~w_done_q & s.wready;
      m0.bvalid  = w_resp & ~wgnt_q & s.bvalid;
      m1.bvalid  = w_resp &  wgnt_q & s.bvalid;
      m0.bresp   = s.bresp;
      m1.bresp   = s.bresp;
   end

   always_comb begin
      r_fwd      = (rstate_q == RFwd);
      r_resp     = (rstate_q == RResp);
      s.araddr   = rgnt_q ? m1.araddr : m0.araddr;
      s.arprot   = rgnt_q ? m1.arprot : m0.arprot;
      s.arvalid  = r_fwd & (rgnt_q ? m1.arvalid : m0.arvalid);
      s.rready   = r_resp & (rgnt_q ? m1.rready : m0.rready);
      m0.arready = r_fwd & ~rgnt_q & s.arready;
      m1.arready = r_fwd &  rgnt_q & s.arready;
      m0.rvalid  = r_resp & ~rgnt_q & s.rvalid;
      m1.rvalid  = r_resp &  rgnt_q & s.rvalid;
      m0.rdata   = s.rdata;
      m1.rdata   = s.rdata;
      m0.rresp   = s.rresp;
      m1.rresp   = s.rresp;
   end

   always_comb begin
      aw_hs  = s.awvalid & s.awready;
      w_hs   = s.wvalid & s.wready;
      b_hs   = s.bvalid & s.bready;
      ar_hs  = s.arvalid & s.arready;
      r_hs   = s.rvalid & s.rready;
      aw_all = aw_done_q | aw_hs;
      w_all  = w_done_q | w_hs;
   end

   // last_wgnt resets to 1 so master 0 wins the first tie.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wstate_q    <= WIdle;
         wgnt_q      <= 1'b0;
         last_wgnt_q <= 1'b1;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
      end else begin
         unique case (wstate_q)
            WIdle: begin
               if (m0.awvalid || m1.awvalid) begin
                  wgnt_q   <= w_win;
                  wstate_q <= WFwd;
               end
            end
            WFwd: begin
               if (aw_all && w_all) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  wstate_q  <= WResp;
               end else begin
                  aw_done_q <= aw_all;
                  w_done_q  <= w_all;
               end
            end
            WResp: begin
               if (b_hs) begin
                  last_wgnt_q <= wgnt_q;
                  wstate_q    <= WIdle;
               end
            end
            default: wstate_q <= WIdle;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rstate_q    <= RIdle;
         rgnt_q      <= 1'b0;
         last_rgnt_q <= 1'b1;
      end else begin
         unique case (rstate_q)
            RIdle: begin
               if (m0.arvalid || m1.arvalid) begin
                  rgnt_q   <= r_win;
                  rstate_q <= RFwd;
               end
            end
            RFwd: begin
               if (ar_hs) begin
                  rstate_q <= RResp;
               end
            end
            RResp: begin
               if (r_hs) begin
                  last_rgnt_q <= rgnt_q;
                  rstate_q    <= RIdle;
               end
            end
            default: rstate_q <= RIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4l_arbiter2.sv
// Directed bench for axi4l_arbiter2: RAM-like slave model behind the round-robin
// instance, plus a small always-ready fixed-priority instance for tie ordering.
module tb_axi4l_arbiter2;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   axi4l_if m0_if ();
   axi4l_if m1_if ();
   axi4l_if s_if ();

   axi4l_arbiter2 #(.fixed_priority(1'b0)) dut (
      .aclk(clk), .aresetn(rstn), .m0(m0_if), .m1(m1_if), .s(s_if)
   );

   // Bench-side master drive and observe, indexed by master number.
   logic        awv [2];
   logic [31:0] awa [2];
   logic        wv  [2];
   logic [31:0] wd  [2];
   logic [3:0]  ws  [2];
   logic        bry [2];
   logic        arv [2];
   logic [31:0] ara [2];
   logic        rry [2];
   logic        awr [2];
   logic        wrdy[2];
   logic        bv  [2];
   logic [1:0]  br  [2];
   logic        arr [2];
   logic        rv  [2];
   logic [31:0] rdt [2];

   assign m0_if.awvalid = awv[0];  assign m1_if.awvalid = awv[1];
   assign m0_if.awaddr  = awa[0];  assign m1_if.awaddr  = awa[1];
   assign m0_if.awprot  = 3'd0;    assign m1_if.awprot  = 3'd0;
   assign m0_if.wvalid  = wv[0];   assign m1_if.wvalid  = wv[1];
   assign m0_if.wdata   = wd[0];   assign m1_if.wdata   = wd[1];
   assign m0_if.wstrb   = ws[0];   assign m1_if.wstrb   = ws[1];
   assign m0_if.bready  = bry[0];  assign m1_if.bready  = bry[1];
   assign m0_if.arvalid = arv[0];  assign m1_if.arvalid = arv[1];
   assign m0_if.araddr  = ara[0];  assign m1_if.araddr  = ara[1];
   assign m0_if.arprot  = 3'd0;    assign m1_if.arprot  = 3'd0;
   assign m0_if.rready  = rry[0];  assign m1_if.rready  = rry[1];
   assign awr[0]  = m0_if.awready; assign awr[1]  = m1_if.awready;
   assign wrdy[0] = m0_if.wready;  assign wrdy[1] = m1_if.wready;
   assign bv[0]   = m0_if.bvalid;  assign bv[1]   = m1_if.bvalid;
   assign br[0]   = m0_if.bresp;   assign br[1]   = m1_if.bresp;
   assign arr[0]  = m0_if.arready; assign arr[1]  = m1_if.arready;
   assign rv[0]   = m0_if.rvalid;  assign rv[1]   = m1_if.rvalid;
   assign rdt[0]  = m0_if.rdata;   assign rdt[1]  = m1_if.rdata;

   logic [14:0] all_out;
   assign all_out = {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready,
                     m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.arready, m0_if.rvalid,
                     m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.arready, m1_if.rvalid};

   // RAM slave: AW and W accepted independently, write when both held.
   logic        sl_aw_got, sl_w_got, sl_bvalid, sl_rvalid;
   logic [31:0] sl_addr, sl_data, sl_rdata;
   logic [3:0]  sl_strb;
   logic [31:0] mem [64];
   int          sl_wr_cnt = 0;

   assign s_if.awready = ~sl_aw_got & ~sl_bvalid;
   assign s_if.wready  = ~sl_w_got & ~sl_bvalid;
   assign s_if.bvalid  = sl_bvalid;
   assign s_if.bresp   = 2'b00;
   assign s_if.arready = ~sl_rvalid;
   assign s_if.rvalid  = sl_rvalid;
   assign s_if.rdata   = sl_rdata;
   assign s_if.rresp   = 2'b00;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sl_aw_got <= 1'b0;
         sl_w_got  <= 1'b0;
         sl_bvalid <= 1'b0;
         sl_rvalid <= 1'b0;
         sl_addr   <= '0;
         sl_data   <= '0;
         sl_strb   <= '0;
         sl_rdata  <= '0;
      end else begin
         if (s_if.awvalid && s_if.awready) begin
            sl_aw_got <= 1'b1;
            sl_addr   <= s_if.awaddr;
         end
         if (s_if.wvalid && s_if.wready) begin
            sl_w_got <= 1'b1;
            sl_data  <= s_if.wdata;
            sl_strb  <= s_if.wstrb;
         end
         if (sl_aw_got && sl_w_got) begin
            for (int b = 0; b < 4; b++) begin
               if (sl_strb[b]) mem[sl_addr[7:2]][8*b +: 8] <= sl_data[8*b +: 8];
            end
            sl_aw_got <= 1'b0;
            sl_w_got  <= 1'b0;
            sl_bvalid <= 1'b1;
            sl_wr_cnt <= sl_wr_cnt + 1;
         end
         if (sl_bvalid && s_if.bready) sl_bvalid <= 1'b0;
         if (s_if.arvalid && s_if.arready) begin
            sl_rvalid <= 1'b1;
            sl_rdata  <= mem[s_if.araddr[7:2]];
         end
         if (sl_rvalid && s_if.rready) sl_rvalid <= 1'b0;
      end
   end

   // m1 must see no ready/response while m0 alone is served.
   logic mon_quiet = 1'b0;
   int   quiet_bad = 0;
   always @(negedge clk) begin
      if (mon_quiet && (awr[1] || wrdy[1] || bv[1])) quiet_bad <= quiet_bad + 1;
   end

   // Fixed-priority instance: both masters request 3 writes continuously.
   axi4l_if fp_m0 ();
   axi4l_if fp_m1 ();
   axi4l_if fp_s ();

   axi4l_arbiter2 #(.fixed_priority(1'b1)) dut_fp (
      .aclk(clk), .aresetn(rstn), .m0(fp_m0), .m1(fp_m1), .s(fp_s)
   );

   logic fp_en = 1'b0;
   int   fp_cnt0 = 0;
   int   fp_cnt1 = 0;
   logic fp_b;
   int   fp_order[$];

   assign fp_m0.awvalid = fp_en && (fp_cnt0 < 3);
   assign fp_m0.wvalid  = fp_en && (fp_cnt0 < 3);
   assign fp_m1.awvalid = fp_en && (fp_cnt1 < 3);
   assign fp_m1.wvalid  = fp_en && (fp_cnt1 < 3);
   assign fp_m0.awaddr = '0;  assign fp_m1.awaddr = '0;
   assign fp_m0.awprot = '0;  assign fp_m1.awprot = '0;
   assign fp_m0.wdata  = '0;  assign fp_m1.wdata  = '1;
   assign fp_m0.wstrb  = '1;  assign fp_m1.wstrb  = '1;
   assign fp_m0.bready = 1'b1; assign fp_m1.bready = 1'b1;
   assign fp_m0.arvalid = 1'b0; assign fp_m1.arvalid = 1'b0;
   assign fp_m0.araddr = '0;  assign fp_m1.araddr = '0;
   assign fp_m0.arprot = '0;  assign fp_m1.arprot = '0;
   assign fp_m0.rready = 1'b0; assign fp_m1.rready = 1'b0;
   assign fp_s.awready = 1'b1;
   assign fp_s.wready  = 1'b1;
   assign fp_s.bvalid  = fp_b;
   assign fp_s.bresp   = 2'b00;
   assign fp_s.arready = 1'b0;
   assign fp_s.rvalid  = 1'b0;
   assign fp_s.rdata   = '0;
   assign fp_s.rresp   = 2'b00;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) fp_b <= 1'b0;
      else if (fp_s.awvalid && fp_s.awready) fp_b <= 1'b1;
      else if (fp_b && fp_s.bready) fp_b <= 1'b0;
   end

   always @(posedge clk) begin
      if (fp_m0.awvalid && fp_m0.awready) fp_cnt0 <= fp_cnt0 + 1;
      if (fp_m1.awvalid && fp_m1.awready) fp_cnt1 <= fp_cnt1 + 1;
      if (fp_m0.bvalid && fp_m0.bready) fp_order.push_back(0);
      if (fp_m1.bvalid && fp_m1.bready) fp_order.push_back(1);
   end

   int worder[$];
   int rorder[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   // All master tasks are entered just after a rising edge.
   task automatic send(input int idx, input logic [31:0] a, input logic [31:0] d, output bit ok);
      bit ad = 1'b0;
      bit wdn = 1'b0;
      awv[idx] = 1'b1; awa[idx] = a;
      wv[idx]  = 1'b1; wd[idx]  = d; ws[idx] = 4'hF;
      for (int c = 0; c < 80 && !(ad && wdn); c++) begin
         @(negedge clk);
         if (awv[idx] && awr[idx]) ad = 1'b1;
         if (wv[idx] && wrdy[idx]) wdn = 1'b1;
         @(posedge clk); #1;
         if (ad) awv[idx] = 1'b0;
         if (wdn) wv[idx] = 1'b0;
      end
      awv[idx] = 1'b0;
      wv[idx]  = 1'b0;
      ok = ad && wdn;
   endtask

   task automatic get_b(input int idx, output logic [1:0] resp, output bit ok);
      bit got = 1'b0;
      resp = 2'b11;
      bry[idx] = 1'b1;
      for (int c = 0; c < 80 && !got; c++) begin
         @(negedge clk);
         if (bv[idx]) begin
            got  = 1'b1;
            resp = br[idx];
            worder.push_back(idx);
         end
         @(posedge clk); #1;
      end
      bry[idx] = 1'b0;
      ok = got;
   endtask

   task automatic wr(input int idx, input logic [31:0] a, input logic [31:0] d,
                     output logic [1:0] resp, output bit ok);
      bit k1, k2;
      resp = 2'b11;
      k2 = 1'b0;
      send(idx, a, d, k1);
      if (k1) get_b(idx, resp, k2);
      ok = k1 && k2;
   endtask

   task automatic rd(input int idx, input logic [31:0] a, output logic [31:0] d, output bit ok);
      bit ac = 1'b0;
      bit got = 1'b0;
      d = '0;
      arv[idx] = 1'b1; ara[idx] = a;
      for (int c = 0; c < 80 && !ac; c++) begin
         @(negedge clk);
         if (arr[idx]) ac = 1'b1;
         @(posedge clk); #1;
         if (ac) arv[idx] = 1'b0;
      end
      arv[idx] = 1'b0;
      if (ac) begin
         rry[idx] = 1'b1;
         for (int c = 0; c < 80 && !got; c++) begin
            @(negedge clk);
            if (rv[idx]) begin
               got = 1'b1;
               d   = rdt[idx];
               rorder.push_back(idx);
            end
            @(posedge clk); #1;
         end
         rry[idx] = 1'b0;
      end
      ok = ac && got;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r0, r1;
      logic [31:0] d0, d1;
      bit          k0, k1, kb, okall;
      int          wbase;
      int          fpexp[6];
      fpexp = '{0, 0, 0, 1, 1, 1};
      for (int i = 0; i < 2; i++) begin
         awv[i] = 1'b0; awa[i] = '0; wv[i] = 1'b0; wd[i] = '0; ws[i] = '0;
         bry[i] = 1'b0; arv[i] = 1'b0; ara[i] = '0; rry[i] = 1'b0;
      end

      // Requests during reset must not leak to any output.
      awv[0] = 1'b1; arv[1] = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", 32'(all_out), 32'd0);
      awv[0] = 1'b0; arv[1] = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      fp_en = 1'b1;
      @(posedge clk); #1;

      // Single write from m0, one cycle of arbitration latency.
      mon_quiet = 1'b1;
      fork
         wr(0, 32'h10, 32'hDEADBEEF, r0, k0);
         begin
            @(negedge clk);
            chk("aw_lat_idle", 32'(s_if.awvalid), 32'd0);
            @(negedge clk);
            chk("aw_lat_fwd", 32'(s_if.awvalid), 32'd1);
            chk("aw_addr", s_if.awaddr, 32'h10);
            chk("w_data", s_if.wdata, 32'hDEADBEEF);
         end
      join
      mon_quiet = 1'b0;
      chk("wr1_ok", 32'(k0), 32'd1);
      chk("wr1_bresp", 32'(r0), 32'd0);
      chk("wr1_m1_quiet", 32'(quiet_bad), 32'd0);
      chk("wr1_mem", mem[4], 32'hDEADBEEF);

      // Preload; the second one leaves last write grant at m1.
      wr(0, 32'h04, 32'h11111111, r0, k0);
      wr(1, 32'h08, 32'h22222222, r1, k1);
      chk("preload_ok", 32'({k0, k1}), 32'd3);

      // Tied reads: m0 first twice in a row.
      rorder.delete();
      fork
         rd(0, 32'h04, d0, k0);
         rd(1, 32'h08, d1, k1);
      join
      chk("rtie1_ok", 32'({k0, k1}), 32'd3);
      chk("rtie1_d0", d0, 32'h11111111);
      chk("rtie1_d1", d1, 32'h22222222);
      chk("rtie1_n", 32'(rorder.size()), 32'd2);
      chk("rtie1_first", 32'(rorder[0]), 32'd0);
      rorder.delete();
      fork
         rd(0, 32'h08, d0, k0);
         rd(1, 32'h04, d1, k1);
      join
      chk("rtie2_d0", d0, 32'h22222222);
      chk("rtie2_d1", d1, 32'h11111111);
      chk("rtie2_first", 32'(rorder[0]), 32'd0);

      // Round-robin fairness over 4+4 back-to-back writes.
      worder.delete();
      okall = 1'b1;
      fork
         for (int i = 0; i < 4; i++) begin
            wr(0, 32'h40 + 32'(4 * i), 32'(i), r0, k0);
            okall = okall & k0 & (r0 == 2'b00);
         end
         for (int i = 0; i < 4; i++) begin
            wr(1, 32'h80 + 32'(4 * i), 32'h100 + 32'(i), r1, k1);
            okall = okall & k1 & (r1 == 2'b00);
         end
      join
      chk("rr_ok", 32'(okall), 32'd1);
      chk("rr_n", 32'(worder.size()), 32'd8);
      for (int i = 0; i < 8; i++) chk("rr_order", 32'(worder[i]), 32'(i % 2));
      chk("rr_mem0", mem[19], 32'd3);
      chk("rr_mem1", mem[35], 32'h103);

      // W ahead of AW on m1, B backpressure while m0 waits.
      wbase = sl_wr_cnt;
      fork
         begin
            wv[1] = 1'b1; wd[1] = 32'hCAFEF00D; ws[1] = 4'hF;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("skew_w_alone", 32'({s_if.wvalid, wrdy[1]}), 32'd0);
            @(posedge clk); #1;
            send(1, 32'h0C, 32'hCAFEF00D, k1);
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("bp_bvalid", 32'(bv[1]), 32'd1);
            chk("bp_no_grant", 32'({awr[0], s_if.awvalid}), 32'd0);
            chk("bp_one_write", 32'(sl_wr_cnt), 32'(wbase + 1));
            @(posedge clk); #1;
            get_b(1, r1, kb);
         end
         begin
            repeat (6) @(posedge clk); #1;
            wr(0, 32'h30, 32'h12345678, r0, k0);
         end
      join
      chk("skew_ok", 32'({k1, kb, k0}), 32'd7);
      chk("skew_resp", 32'({r1, r0}), 32'd0);
      chk("skew_writes", 32'(sl_wr_cnt), 32'(wbase + 2));
      chk("skew_mem1", mem[3], 32'hCAFEF00D);
      chk("skew_mem0", mem[12], 32'h12345678);

      // Concurrent write (m0) and read (m1) of the same word.
      fork
         wr(0, 32'h20, 32'hA5A5A5A5, r0, k0);
         rd(1, 32'h20, d1, k1);
      join
      chk("conc_ok", 32'({k0, k1}), 32'd3);
      chk("conc_bresp", 32'(r0), 32'd0);
      rd(1, 32'h20, d1, k1);
      chk("conc_readback", d1, 32'hA5A5A5A5);

      // Reset while in write-forward with AW already accepted.
      awv[1] = 1'b1; awa[1] = 32'h50;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_aw", 32'(s_if.awvalid), 32'd1);
      @(posedge clk); #1;
      awv[1] = 1'b0;
      wv[1] = 1'b1; wd[1] = 32'h0BADCAFE; ws[1] = 4'hF;
      @(negedge clk);
      chk("rst_mid_awdone", 32'({s_if.awvalid, s_if.wvalid}), 32'd1);
      #2 rstn = 1'b0;
      #1 chk("rst_async_outs", 32'(all_out), 32'd0);
      wv[1] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      wr(1, 32'h50, 32'h0BADCAFE, r1, k1);
      chk("post_rst_wr", 32'({k1, r1}), 32'd4);
      rd(0, 32'h50, d0, k0);
      chk("post_rst_rd", d0, 32'h0BADCAFE);

      // Fixed-priority instance: all m0 writes before m1's.
      chk("fp_n", 32'(fp_order.size()), 32'd6);
      for (int i = 0; i < 6; i++) chk("fp_order", 32'(fp_order[i]), 32'(fpexp[i]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
